// File: rtl/vec_scale_pipe.sv
// Two-stage pipelined fixed-point vector scaler with valid/ready on both sides.
// S1 holds full-width per-lane products; S2 holds the rounded, range-checked, limited lanes.

module vsp_lane #(
    parameter int WIDTH    = 32,
    parameter int FRAC     = 16,
    parameter int SATURATE = 1
) (
    input  logic [2*WIDTH-1:0] prod_i,
    output logic [WIDTH-1:0]   res_o,
    output logic               ovf_o
);
    localparam int PW = 2 * WIDTH;
    localparam logic [PW-1:0]    ONE  = {{(PW-1){1'b0}}, 1'b1};
    // Half an output LSB; collapses to zero when FRAC is 0.
    localparam logic [PW-1:0]    RND  = (ONE << FRAC) >> 1;
    localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    logic [PW-1:0]       rnd;
    logic [PW-1:0]       shr;
    logic [PW-WIDTH:0]   top;

    // The product magnitude is at most 2^(PW-2), so adding RND cannot wrap.
    assign rnd   = prod_i + RND;
    assign shr   = $signed(rnd) >>> FRAC;
    assign top   = shr[PW-1:WIDTH-1];
    assign ovf_o = !((&top) || !(|top));

    always_comb begin
        res_o = shr[WIDTH-1:0];
        if (SATURATE != 0 && ovf_o) res_o = shr[PW-1] ? MINV : MAXV;
    end
endmodule

module vec_scale_pipe #(
    parameter int WIDTH    = 32,
    parameter int FRAC     = 16,
    parameter int LANES    = 3,
    parameter int SATURATE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_vec,
    input  logic [WIDTH-1:0]       in_scale,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_vec,
    output logic [LANES-1:0]       out_ovf,
    output logic                   ovf_sticky,
    input  logic                   clr_ovf
);
    localparam int PW = 2 * WIDTH;

    logic [2:1]                   vld_pipe_q;
    logic                         s1_load, s2_load;
    logic [LANES-1:0][PW-1:0]     s1_prod_q, s1_prod_d;
    logic [LANES-1:0][WIDTH-1:0]  s2_vec_q, s2_vec_d;
    logic [LANES-1:0]             s2_ovf_q, s2_ovf_d;
    logic                         sticky_q, sticky_d;

    // in_ready depends only on state and out_ready, never on in_valid.
    assign s2_load  = !vld_pipe_q[2] || out_ready;
    assign s1_load  = !vld_pipe_q[1] || s2_load;
    assign in_ready = s1_load;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [WIDTH-1:0] a;
        assign a = in_vec[k*WIDTH +: WIDTH];
        // Sign-extend both operands so the low PW bits are the signed product.
        assign s1_prod_d[k] = {{WIDTH{a[WIDTH-1]}}, a} *
                              {{WIDTH{in_scale[WIDTH-1]}}, in_scale};

        vsp_lane #(
            .WIDTH    (WIDTH),
            .FRAC     (FRAC),
            .SATURATE (SATURATE)
        ) u_lane (
            .prod_i (s1_prod_q[k]),
            .res_o  (s2_vec_d[k]),
            .ovf_o  (s2_ovf_d[k])
        );
    end

    always_comb begin
        sticky_d = sticky_q;
        if (clr_ovf) sticky_d = 1'b0;
        if (vld_pipe_q[2] && out_ready && (|s2_ovf_q)) sticky_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            s1_prod_q  <= '0;
            s2_vec_q   <= '0;
            s2_ovf_q   <= '0;
            sticky_q   <= 1'b0;
        end else begin
            if (s1_load) begin
                vld_pipe_q[1] <= in_valid;
                if (in_valid) s1_prod_q <= s1_prod_d;
            end
            if (s2_load) begin
                vld_pipe_q[2] <= vld_pipe_q[1];
                if (vld_pipe_q[1]) begin
                    s2_vec_q <= s2_vec_d;
                    s2_ovf_q <= s2_ovf_d;
                end
            end
            sticky_q <= sticky_d;
        end
    end

    assign out_valid  = vld_pipe_q[2];
    assign out_vec    = s2_vec_q;
    assign out_ovf    = s2_ovf_q;
    assign ovf_sticky = sticky_q;
endmodule

// File: tb/tb_vec_scale_pipe.sv
// Directed and random checks for vec_scale_pipe; a wrap-mode instance shares the same stimulus.
module tb_vec_scale_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready, clr_ovf;
    logic [95:0] in_vec;
    logic [31:0] in_scale;
    logic        in_ready, out_valid, ovf_sticky;
    logic [95:0] out_vec;
    logic [2:0]  out_ovf;
    logic        w_in_ready, w_out_valid, w_ovf_sticky;
    logic [95:0] w_out_vec;
    logic [2:0]  w_out_ovf;

    always #5 clk = ~clk;

    vec_scale_pipe #(.WIDTH(32), .FRAC(16), .LANES(3), .SATURATE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_vec(in_vec), .in_scale(in_scale), .out_valid(out_valid),
        .out_ready(out_ready), .out_vec(out_vec), .out_ovf(out_ovf),
        .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf));

    vec_scale_pipe #(.WIDTH(32), .FRAC(16), .LANES(3), .SATURATE(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_vec(in_vec), .in_scale(in_scale), .out_valid(w_out_valid),
        .out_ready(out_ready), .out_vec(w_out_vec), .out_ovf(w_out_ovf),
        .ovf_sticky(w_ovf_sticky), .clr_ovf(clr_ovf));

    typedef struct {
        logic [95:0] vec;
        logic [31:0] scale;
        logic [95:0] exp_sat;
        logic [2:0]  exp_ovf;
        logic [95:0] exp_wrap;
    } vec_t;

    typedef struct {
        logic [95:0] sat;
        logic [95:0] wrap;
        logic [2:0]  ovf;
    } exp_t;

    int   n_chk = 0;
    int   n_fail = 0;
    int   rx_cnt = 0;
    int   cyc_n = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];
    int   out_t[$];

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Independent bit-exact reference using 64-bit integer arithmetic.
    task automatic model(input logic [95:0] v, input logic [31:0] s,
                         output logic [95:0] o_sat, output logic [95:0] o_wrap,
                         output logic [2:0] f);
        longint a, b, p, r;
        logic [63:0] rb;
        for (int k = 0; k < 3; k++) begin
            a = longint'($signed(v[k*32 +: 32]));
            b = longint'($signed(s));
            p = a * b;
            r = (p + 64'sd32768) >>> 16;
            rb = r;
            f[k] = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            o_wrap[k*32 +: 32] = rb[31:0];
            if (f[k]) o_sat[k*32 +: 32] = (r < 0) ? 32'h80000000 : 32'h7FFFFFFF;
            else      o_sat[k*32 +: 32] = rb[31:0];
        end
    endtask

    task automatic push_exp(input logic [95:0] v, input logic [31:0] s);
        exp_t e;
        model(v, s, e.sat, e.wrap, e.ovf);
        exp_q.push_back(e);
    endtask

    // Outputs are sampled mid-cycle; a transfer seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", out_vec, 'x);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_vec", out_vec, e.sat);
                chk("sb_ovf", out_ovf, e.ovf);
                chk("sb_wrap_vec", w_out_vec, e.wrap);
                chk("sb_wrap_ovf", w_out_ovf, e.ovf);
            end
            rx_cnt++;
            out_t.push_back(cyc_n);
        end
    end

    // Presents one vector until accepted (inputs change only just after a rising edge).
    task automatic send_one(input logic [95:0] v, input logic [31:0] s);
        bit acc = 1'b0;
        int t = 0;
        in_valid = 1'b1; in_vec = v; in_scale = s;
        while (!acc && t < 60) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) push_exp(v, s);
            @(posedge clk); #1;
            t++;
        end
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[6];
    logic [95:0] rv;
    logic [31:0] rs, tmp;
    int   lat, rx0, idx;
    bit   done;

    initial begin
        tbl[0] = '{96'h00018000_FFFD0000_00004000, 32'h00020000,
                   96'h00030000_FFFA0000_00008000, 3'b000, 96'h00030000_FFFA0000_00008000};
        tbl[1] = '{96'h40000000_C0000000_00010000, 32'h00040000,
                   96'h7FFFFFFF_80000000_00040000, 3'b110, 96'h00000000_00000000_00040000};
        tbl[2] = '{96'h00000001_FFFFFFFF_00000003, 32'h00008000,
                   96'h00000001_00000000_00000002, 3'b000, 96'h00000001_00000000_00000002};
        tbl[3] = '{96'h80000000_00010000_00000000, 32'h80000000,
                   96'h7FFFFFFF_80000000_00000000, 3'b100, 96'h00000000_80000000_00000000};
        tbl[4] = '{96'h00018000_FFFD0000_7FFFFFFF, 32'hFFFF0000,
                   96'hFFFE8000_00030000_80000001, 3'b000, 96'hFFFE8000_00030000_80000001};
        tbl[5] = '{96'hFFFFFFFD_7FFFFFFF_80000000, 32'h00008000,
                   96'hFFFFFFFF_40000000_C0000000, 3'b000, 96'hFFFFFFFF_40000000_C0000000};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
        in_vec = '0; in_scale = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_vec", out_vec, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_sticky", ovf_sticky, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", in_ready, 1);

        // Directed table, one vector at a time with out_ready high.
        for (int i = 0; i < 6; i++) begin
            clr_ovf = 1'b1;
            @(posedge clk); #1;
            clr_ovf = 1'b0;
            out_ready = 1'b1;
            in_valid = 1'b1; in_vec = tbl[i].vec; in_scale = tbl[i].scale;
            @(negedge clk);
            chk($sformatf("t%0d_in_ready", i), in_ready, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 8) begin
                @(posedge clk); #1;
                lat++;
            end
            chk($sformatf("t%0d_latency", i), lat, 2);
            chk($sformatf("t%0d_vec", i), out_vec, tbl[i].exp_sat);
            chk($sformatf("t%0d_ovf", i), out_ovf, tbl[i].exp_ovf);
            chk($sformatf("t%0d_wrap_vec", i), w_out_vec, tbl[i].exp_wrap);
            chk($sformatf("t%0d_wrap_ovf", i), w_out_ovf, tbl[i].exp_ovf);
            @(posedge clk); #1;
            chk($sformatf("t%0d_sticky", i), ovf_sticky, |tbl[i].exp_ovf);
            chk($sformatf("t%0d_valid_drop", i), out_valid, 0);
        end

        // Backpressure: four back-to-back vectors, out_ready low for five cycles.
        mon_en = 1'b1;
        out_t.delete();
        out_ready = 1'b0;
        idx = 0;
        in_valid = 1'b1; in_vec = tbl[0].vec; in_scale = tbl[0].scale;
        for (int c = 0; c < 12; c++) begin
            if (c == 5) out_ready = 1'b1;
            @(negedge clk);
            if (c == 4) begin
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_accepts_stalled", idx, 2);
            end
            if (in_valid && in_ready) begin
                push_exp(tbl[idx].vec, tbl[idx].scale);
                idx++;
            end
            @(posedge clk); #1;
            if (idx < 4) begin
                in_vec = tbl[idx].vec; in_scale = tbl[idx].scale;
            end else begin
                in_valid = 1'b0;
            end
        end
        chk("bp_out_count", out_t.size(), 4);
        if (out_t.size() == 4)
            for (int i = 1; i < 4; i++) chk("bp_no_gap", out_t[i] - out_t[i-1], 1);
        chk("bp_queue_empty", exp_q.size(), 0);

        // Streaming with random data and random out_ready.
        rx0 = rx_cnt;
        done = 1'b0;
        fork
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 100; i++) begin
                    for (int k = 0; k < 3; k++) begin
                        tmp = $urandom;
                        rv[k*32 +: 32] = $urandom_range(0, 1) ? tmp : {{12{tmp[19]}}, tmp[19:0]};
                    end
                    tmp = $urandom;
                    rs = $urandom_range(0, 1) ? tmp : {{13{tmp[18]}}, tmp[18:0]};
                    send_one(rv, rs);
                end
                in_valid = 1'b0;
                out_ready = 1'b1;
                drain();
                done = 1'b1;
            end
        join
        @(posedge clk); #1;
        chk("stream_count", rx_cnt - rx0, 100);

        // Reset with two vectors in flight; sticky set beforehand.
        out_ready = 1'b1;
        send_one(tbl[1].vec, tbl[1].scale);
        in_valid = 1'b0;
        drain();
        chk("pre_rst_sticky", ovf_sticky, 1);
        out_ready = 1'b0;
        send_one(tbl[1].vec, tbl[1].scale);
        send_one(tbl[3].vec, tbl[3].scale);
        in_valid = 1'b0;
        chk("pre_rst_out_valid", out_valid, 1);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_sticky", ovf_sticky, 0);
        chk("mid_rst_out_vec", out_vec, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        mon_en = 1'b1;
        rx0 = rx_cnt;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_stale", out_valid, 0);
        end
        @(posedge clk); #1;
        send_one(tbl[0].vec, tbl[0].scale);
        in_valid = 1'b0;
        drain();
        chk("post_rst_count", rx_cnt - rx0, 1);
        chk("post_rst_sticky", ovf_sticky, 0);

        // Sticky clear without overflow, then clear colliding with an overflow transfer.
        send_one(tbl[1].vec, tbl[1].scale);
        in_valid = 1'b0;
        drain();
        chk("sticky_set", ovf_sticky, 1);
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        chk("sticky_clr", ovf_sticky, 0);
        out_ready = 1'b0;
        send_one(tbl[3].vec, tbl[3].scale);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("collide_out_valid", out_valid, 1);
        out_ready = 1'b1;
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        chk("sticky_set_wins", ovf_sticky, 1);
        chk("collide_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
